// File: rtl/iram_arbiter.sv
// Round-robin arbiter sharing the single-port 128x8 internal data RAM between the
// execute unit (port 0) and the stack/interrupt unit (port 1).
module iram_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              read_en,
  output logic              write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              pref1_q, pref1_d;
  logic              locked_q, locked_d;
  logic              owner_q, owner_d;
  logic              ram_en_q, ram_en_d;
  logic              read_en_q, read_en_d;
  logic              write_en_q, write_en_d;
  logic              iss_port_q, iss_port_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              m0_rvalid_q, m0_rvalid_d;
  logic              m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  // A held lock shuts out the other port even while the owner is idle.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (locked_q) begin
        m0_gnt = !owner_q && m0_req;
        m1_gnt = owner_q && m1_req;
      end else if (m0_req && m1_req) begin
        m0_gnt = !pref1_q;
        m1_gnt = pref1_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    pref1_d     = pref1_q;
    locked_d    = locked_q;
    owner_d     = owner_q;
    ram_en_d    = 1'b0;
    read_en_d   = 1'b0;
    write_en_d  = 1'b0;
    iss_port_d  = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (m0_gnt) begin
      pref1_d     = 1'b1;
      locked_d    = m0_lock;
      owner_d     = 1'b0;
      ram_en_d    = 1'b1;
      read_en_d   = !m0_we;
      write_en_d  = m0_we;
      ram_addr_d  = m0_addr;
      ram_wdata_d = m0_we ? m0_wdata : '0;
    end else if (m1_gnt) begin
      pref1_d     = 1'b0;
      locked_d    = m1_lock;
      owner_d     = 1'b1;
      ram_en_d    = 1'b1;
      read_en_d   = !m1_we;
      write_en_d  = m1_we;
      iss_port_d  = 1'b1;
      ram_addr_d  = m1_addr;
      ram_wdata_d = m1_we ? m1_wdata : '0;
    end
    // Read data is captured at the end of the issue cycle and then held per port.
    m0_rvalid_d = read_en_q && !iss_port_q;
    m1_rvalid_d = read_en_q && iss_port_q;
    m0_rdata_d  = m0_rvalid_d ? ram_rdata : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? ram_rdata : m1_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref1_q     <= 1'b0;
      locked_q    <= 1'b0;
      owner_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      read_en_q   <= 1'b0;
      write_en_q  <= 1'b0;
      iss_port_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      pref1_q     <= pref1_d;
      locked_q    <= locked_d;
      owner_q     <= owner_d;
      ram_en_q    <= ram_en_d;
      read_en_q   <= read_en_d;
      write_en_q  <= write_en_d;
      iss_port_q  <= iss_port_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign read_en   = read_en_q;
  assign write_en  = write_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_iram_arbiter.sv
// Bench for iram_arbiter: directed per-cycle vector table, then random traffic
// checked against a transaction-level model of the shared RAM.
module tb_iram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       rq_req[2], rq_we[2], rq_lock[2];
  logic [6:0] rq_addr[2];
  logic [7:0] rq_wdata[2];
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       ram_en, read_en, write_en;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [7:0] ram [128];
  logic       ram_init;
  int         n_cmp = 0;
  int         n_err = 0;

  typedef struct {
    logic [1:0] rst;
    logic [2:0] c0;
    logic [6:0] a0;
    logic [7:0] d0;
    logic [2:0] c1;
    logic [6:0] a1;
    logic [7:0] d1;
    logic [4:0] ctl;
    logic [6:0] addr;
    logic [7:0] wdat;
    logic [1:0] v;
    logic [7:0] q0;
    logic [7:0] q1;
  } vec_t;

  typedef struct {
    int         port;
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         due;
  } acc_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } ret_t;

  vec_t       vecs[$];
  acc_t       pend[$];
  ret_t       rets[$];
  logic [7:0] refmem [128];
  logic [7:0] eq[2];
  int         last_port;
  int         owner;

  iram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(rq_req[0]), .m0_we(rq_we[0]), .m0_lock(rq_lock[0]),
    .m0_addr(rq_addr[0]), .m0_wdata(rq_wdata[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(rq_req[1]), .m1_we(rq_we[1]), .m1_lock(rq_lock[1]),
    .m1_addr(rq_addr[1]), .m1_wdata(rq_wdata[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .read_en(read_en), .write_en(write_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write at the clock edge.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= 8'h80 | 8'(i);
    end else if (write_en) begin
      ram[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_addr];

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s @%0d: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic compareAll(input int idx, input logic [4:0] e_ctl, input logic [6:0] e_addr,
                            input logic [7:0] e_wdat, input logic [1:0] e_v,
                            input logic [7:0] e_q0, input logic [7:0] e_q1);
    checkOutput("m0_gnt",    idx, 32'(m0_gnt),    32'(e_ctl[4]));
    checkOutput("m1_gnt",    idx, 32'(m1_gnt),    32'(e_ctl[3]));
    checkOutput("ram_en",    idx, 32'(ram_en),    32'(e_ctl[2]));
    checkOutput("read_en",   idx, 32'(read_en),   32'(e_ctl[1]));
    checkOutput("write_en",  idx, 32'(write_en),  32'(e_ctl[0]));
    checkOutput("ram_addr",  idx, 32'(ram_addr),  32'(e_addr));
    checkOutput("ram_wdata", idx, 32'(ram_wdata), 32'(e_wdat));
    checkOutput("m0_rvalid", idx, 32'(m0_rvalid), 32'(e_v[1]));
    checkOutput("m1_rvalid", idx, 32'(m1_rvalid), 32'(e_v[0]));
    checkOutput("m0_rdata",  idx, 32'(m0_rdata),  32'(e_q0));
    checkOutput("m1_rdata",  idx, 32'(m1_rdata),  32'(e_q1));
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst[1];
    {rq_req[0], rq_we[0], rq_lock[0]} = v.c0;
    rq_addr[0]  = v.a0;
    rq_wdata[0] = v.d0;
    {rq_req[1], rq_we[1], rq_lock[1]} = v.c1;
    rq_addr[1]  = v.a1;
    rq_wdata[1] = v.d1;
  endtask

  // Grant rule: owner only while locked, else the port that did not win last time.
  function automatic int model_grant();
    if (!rst_n) return -1;
    if (owner >= 0) return rq_req[owner] ? owner : -1;
    if (rq_req[0] && rq_req[1]) return 1 - last_port;
    if (rq_req[0]) return 0;
    if (rq_req[1]) return 1;
    return -1;
  endfunction

  initial begin
    int         eg;
    logic       acc[2];
    logic [4:0] e_ctl;
    logic [6:0] e_addr;
    logic [7:0] e_wdat;
    logic [1:0] e_v;
    logic       iss_now, ret_now;

    // Each record is one cycle: {rst_n,late_rst}, port0 {req,we,lock},addr,wdata, port1 ditto,
    // expected {g0,g1,en,rd,wr}, addr, wdata, {rv0,rv1}, rdata0, rdata1.
    vecs.push_back('{2'b10,3'b110,7'h10,8'hA5,3'b000,7'h00,8'h00,5'b10000,7'h00,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h10,8'h00,3'b000,7'h00,8'h00,5'b10101,7'h10,8'hA5,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00110,7'h10,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b10,8'hA5,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'hA5,8'h00});
    vecs.push_back('{2'b00,3'b100,7'h10,8'h00,3'b100,7'h11,8'h00,5'b00000,7'h00,8'h00,2'b00,8'hA5,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h10,8'h00,3'b100,7'h11,8'h00,5'b10000,7'h00,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h10,8'h00,3'b100,7'h11,8'h00,5'b01110,7'h10,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h10,8'h00,3'b100,7'h11,8'h00,5'b10110,7'h11,8'h00,2'b10,8'hA5,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h10,8'h00,3'b100,7'h11,8'h00,5'b01110,7'h10,8'h00,2'b01,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00110,7'h11,8'h00,2'b10,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b01,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b101,7'h20,8'h00,3'b110,7'h30,8'h77,5'b10000,7'h00,8'h00,2'b00,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h30,8'h77,5'b00110,7'h20,8'h00,2'b00,8'hA5,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h30,8'h77,5'b00000,7'h00,8'h00,2'b10,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b110,7'h20,8'h55,3'b110,7'h30,8'h77,5'b10000,7'h00,8'h00,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h30,8'h77,5'b01101,7'h20,8'h55,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00101,7'h30,8'h77,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h7F,8'h3C,5'b01000,7'h00,8'h00,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b100,7'h7F,8'h00,3'b000,7'h00,8'h00,5'b10101,7'h7F,8'h3C,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00110,7'h7F,8'h00,2'b00,8'hA0,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b10,8'h3C,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h7F,8'h11,5'b01000,7'h00,8'h00,2'b00,8'h3C,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b110,7'h00,8'h22,5'b01101,7'h7F,8'h11,2'b00,8'h3C,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b100,7'h7F,8'h00,5'b01101,7'h00,8'h22,2'b00,8'h3C,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b100,7'h00,8'h00,5'b01110,7'h7F,8'h00,2'b00,8'h3C,8'h91});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00110,7'h00,8'h00,2'b01,8'h3C,8'h11});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b01,8'h3C,8'h22});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'h3C,8'h22});
    vecs.push_back('{2'b11,3'b110,7'h05,8'hFF,3'b000,7'h00,8'h00,5'b10000,7'h00,8'h00,2'b00,8'h3C,8'h22});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b100,7'h05,8'h00,3'b100,7'h00,8'h00,5'b10000,7'h00,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b100,7'h00,8'h00,5'b01110,7'h05,8'h00,2'b00,8'h00,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00110,7'h00,8'h00,2'b10,8'h85,8'h00});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b01,8'h85,8'h22});
    vecs.push_back('{2'b10,3'b000,7'h00,8'h00,3'b000,7'h00,8'h00,5'b00000,7'h00,8'h00,2'b00,8'h85,8'h22});

    rst_n    = 1'b0;
    ram_init = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rq_req[p] = 1'b0; rq_we[p] = 1'b0; rq_lock[p] = 1'b0;
      rq_addr[p] = 7'h00; rq_wdata[p] = 8'h00;
    end
    repeat (2) @(negedge clk);
    ram_init = 1'b0;

    // The late-reset flag pulls rst_n low after the grant is seen, before the accepting edge.
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      compareAll(i + 1, vecs[i].ctl, vecs[i].addr, vecs[i].wdat, vecs[i].v, vecs[i].q0, vecs[i].q1);
      if (vecs[i].rst[0]) begin
        #1;
        rst_n = 1'b0;
      end
    end

    $display("[TB] directed table done, starting random traffic");
    @(negedge clk);
    rst_n    = 1'b0;
    ram_init = 1'b1;
    for (int p = 0; p < 2; p++) rq_req[p] = 1'b0;
    @(negedge clk);
    ram_init = 1'b0;
    for (int i = 0; i < 128; i++) refmem[i] = 8'h80 | 8'(i);
    last_port = 1;
    owner     = -1;
    eq[0]     = 8'h00;
    eq[1]     = 8'h00;
    acc[0]    = 1'b0;
    acc[1]    = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) rq_req[p] = 1'b0;
        if (!rq_req[p] && ($urandom_range(0, 1) == 1)) begin
          rq_req[p]   = 1'b1;
          rq_we[p]    = ($urandom_range(0, 1) == 1);
          rq_lock[p]  = ($urandom_range(0, 3) == 0);
          rq_addr[p]  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'(7'd126 + 7'($urandom_range(0, 3)));
          rq_wdata[p] = 8'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 199) != 0);
      #1;

      eg      = model_grant();
      iss_now = (pend.size() > 0) && (pend[0].due == c);
      ret_now = (rets.size() > 0) && (rets[0].due == c);
      e_ctl   = {eg == 0, eg == 1, 3'b000};
      e_addr  = 7'h00;
      e_wdat  = 8'h00;
      e_v     = 2'b00;
      if (iss_now) begin
        e_ctl[2:0] = {1'b1, !pend[0].we, pend[0].we};
        e_addr     = pend[0].addr;
        e_wdat     = pend[0].we ? pend[0].wdata : 8'h00;
      end
      if (ret_now) begin
        eq[rets[0].port] = rets[0].data;
        e_v[1 - rets[0].port] = 1'b1;
      end
      compareAll(c, e_ctl, e_addr, e_wdat, e_v, eq[0], eq[1]);
      acc[0] = m0_gnt;
      acc[1] = m1_gnt;

      // The RAM still commits a write whose issue cycle coincides with the reset edge.
      if (ret_now) void'(rets.pop_front());
      if (iss_now) begin
        if (pend[0].we) refmem[pend[0].addr] = pend[0].wdata;
        else rets.push_back('{pend[0].port, refmem[pend[0].addr], c + 1});
        void'(pend.pop_front());
      end
      if (!rst_n) begin
        pend.delete();
        rets.delete();
        eq[0]     = 8'h00;
        eq[1]     = 8'h00;
        last_port = 1;
        owner     = -1;
      end else if (eg >= 0) begin
        pend.push_back('{eg, rq_we[eg], rq_addr[eg], rq_wdata[eg], c + 1});
        last_port = eg;
        owner     = rq_lock[eg] ? eg : -1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iram_arbiter.md
Name: iram_arbiter

Overview:
- Shares the single-port 128x8 internal data RAM between two requesters.
- Port 0 is the core execute unit; port 1 is the stack/interrupt push-pop unit.
- Requests are accepted through a req/gnt handshake and issued to the RAM one registered cycle later. Read data returns with rvalid two cycles after grant.
- Round-robin arbitration. A lock qualifier keeps multi-access sequences (read-modify-write, PC push) atomic.

Parameters:
- ADDR_W, 7, RAM address width (128 bytes)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- m0_req  in  1  port 0 request valid
- m0_we  in  1  port 0 write (1) / read (0)
- m0_lock  in  1  port 0 keeps ownership after this access
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 request accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_W  port 0 read data
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- ram_en  out  1  RAM enable
- read_en  out  1  RAM read enable
- write_en  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data

Behaviour:
- Reset (rst_n=0 at posedge):
  - Issue stage and read-return stage cleared.
  - ram_en, read_en, write_en = 0; ram_addr, ram_wdata = 0.
  - m0/m1_rvalid = 0; m0/m1_rdata = 0.
  - Round-robin pointer set to "port 0 preferred"; lock cleared.
  - gnt outputs are 0 while rst_n=0.
  - A reset arriving mid-operation drops all in-flight accesses: no write commits after the reset edge, and no rvalid is produced.
- Handshake:
  - A requester holds req, we, lock, addr and wdata stable until it sees gnt.
  - The request is accepted at the posedge where gnt=1.
  - gnt is combinational from the req inputs and the arbiter state. At most one gnt is high per cycle.
  - One grant per cycle maximum; back-to-back grants are allowed with no bubbles.
- Arbitration, when no lock is held:
  - Only one req high: that port is granted.
  - Both req high: the port not granted most recently wins.
  - The pointer updates on every grant.
- Lock:
  - A granted access with lock=1 makes that port owner.
  - While a port is owner, the other port gets no grant, even if the owner's req is low.
  - Ownership ends at the grant of an owner access with lock=0.
  - A lock set on the same cycle as a request from the other port is resolved by the normal arbitration first.
- Issue stage (cycle N+1 after grant in cycle N):
  - Drives ram_en=1 and ram_addr.
  - Read: read_en=1, write_en=0.
  - Write: write_en=1, read_en=0, ram_wdata driven.
  - The write commits at the end of N+1.
  - Idle cycles: ram_en = read_en = write_en = 0.
- Read return:
  - ram_rdata is captured at the end of N+1.
  - The granted port's rvalid=1 for exactly one cycle, in N+2, with rdata.
  - The other port's rvalid stays 0.
  - rdata holds its value after rvalid falls.
- Ordering:
  - Accesses reach the RAM strictly in grant order.
  - A read granted the cycle after a write to the same address returns the new data, because the write commits before the read issues.
- Unused address/data bits are don't-care, but must be driven deterministically (0) when the issue stage is idle.

Test Plan:
1. Single write then read, port 0: write addr 0x10 data 0xA5 (gnt cycle 1), then read 0x10 (gnt cycle 2) -> write_en=1 in cycle 2; read_en=1 in cycle 3; m0_rvalid=1 with m0_rdata=0xA5 in cycle 4; m1_rvalid stays 0.
2. Simultaneous contention: both ports read continuously from reset -> grants alternate 0,1,0,1; each port's rvalid follows its gnt by exactly 2 cycles; ram_en stays high with no bubbles.
3. Lock / read-modify-write: port 0 reads 0x20 with lock=1, then drops req for 2 cycles, then writes 0x20 with lock=0; port 1 requests throughout -> m1_gnt=0 until the cycle after port 0's unlocking grant; RAM sequence is read 0x20, write 0x20, then port 1's access.
4. Read-after-write across ports: port 1 writes 0x7F=0x3C, port 0 reads 0x7F on the next grant cycle -> m0_rdata=0x3C.
5. Reset mid-operation: grant a write to 0x05 = 0xFF, assert rst_n=0 on the following posedge -> write_en never asserted, 0x05 keeps its old value, all rvalid=0; after release, the first contention grants port 0.
6. Address wrap: port 1 writes 0x7F, then 0x00 -> ram_addr shows 0x7F then 0x00; there is no carry into other bits, and both values read back correctly.
